// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: quadword size, data-memory responder FSM states and
// the processor status codes the core derives from memory errors.
package y86_pkg;

  localparam int QW_BYTES = 8;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Y86-64 Stat encodings; a dmem error surfaces in the core as STAT_ADR.
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Highest legal byte address of a full quadword inside a store of 'depth' bytes.
  function automatic longint unsigned qw_last_addr(input int unsigned depth);
    return longint'(depth) - longint'(QW_BYTES);
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-organised storage with an 8-byte little-endian read port and a byte-lane
// write port; byte i of a quadword lives at addr+i. Contents are never cleared.
module y86_dmem_array
  import y86_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AIW   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [AIW-1:0]            i_addr,
  output logic [8*QW_BYTES-1:0]     o_rdata,
  input  logic                      i_we,
  input  logic [QW_BYTES-1:0]       i_be,
  input  logic [8*QW_BYTES-1:0]     i_wdata
);

  logic [7:0] r_mem [DEPTH];

  // Unaligned access: each lane reads its own byte address independently.
  genvar gi;
  generate
    for (gi = 0; gi < QW_BYTES; gi++) begin : g_rd_lane
      logic [AIW-1:0] w_idx;
      assign w_idx = i_addr + AIW'(gi);
      assign o_rdata[8*gi +: 8] = r_mem[w_idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < QW_BYTES; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr + AIW'(i)] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// Y86-64 data-memory responder: one outstanding quadword request, fixed access latency,
// range-checked. Optional macro DMEM_WRITE_ACK_EN makes writes return a response beat.
module y86_dmem_responder
  import y86_pkg::*;
#(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 2,
  parameter int AW      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  localparam int            AIW      = $clog2(DEPTH);
  localparam logic [AW-1:0] MAX_ADDR = AW'(qw_last_addr(DEPTH));
  localparam logic [3:0]    CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e    r_state;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic           r_addr_err;
  logic [AIW-1:0] r_addr;
  logic [63:0]    r_wdata;
  logic [63:0]    r_rdata;
  logic           r_rsp_err;

  logic           w_accept;
  logic           w_access;
  logic           w_wr_en;
  logic [63:0]    w_rd_data;

  assign w_accept = req_valid && (r_state == DMEM_IDLE);
  assign w_access = (r_state == DMEM_BUSY) && (r_cnt == 4'd0);
  // Gated by state, so a reset before the access cycle drops the pending write.
  assign w_wr_en  = w_access && r_we && !r_addr_err;

  assign req_ready = (r_state == DMEM_IDLE);
  assign rsp_valid = (r_state == DMEM_RESP);
  assign busy      = (r_state != DMEM_IDLE);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;

  y86_dmem_array #(
    .DEPTH (DEPTH),
    .AIW   (AIW)
  ) u_array (
    .clk     (clk),
    .i_addr  (r_addr),
    .o_rdata (w_rd_data),
    .i_we    (w_wr_en),
    .i_be    ({QW_BYTES{1'b1}}),
    .i_wdata (r_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= DMEM_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr_err <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        DMEM_IDLE: begin
          if (w_accept) begin
            r_state    <= DMEM_BUSY;
            r_cnt      <= CNT_INIT;
            r_we       <= req_we;
            r_addr     <= req_addr[AIW-1:0];
            r_wdata    <= req_wdata;
            // Full-width compare: addresses whose addr+7 would wrap are errors.
            r_addr_err <= (req_addr > MAX_ADDR);
          end
        end
        DMEM_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
`ifdef DMEM_WRITE_ACK_EN
            r_state   <= DMEM_RESP;
            r_rdata   <= (r_we || r_addr_err) ? 64'd0 : w_rd_data;
            r_rsp_err <= r_addr_err;
`else
            if (r_we) begin
              r_state <= DMEM_IDLE;
            end else begin
              r_state   <= DMEM_RESP;
              r_rdata   <= r_addr_err ? 64'd0 : w_rd_data;
              r_rsp_err <= r_addr_err;
            end
`endif
          end
        end
        DMEM_RESP: begin
          if (rsp_ready) begin
            r_state <= DMEM_IDLE;
          end
        end
        default: begin
          r_state <= DMEM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Self-checking bench for y86_dmem_responder: table of request vectors through a
// scoreboard queue, plus backpressure and reset-mid-access sequences.
module tb_y86_dmem_responder;

  localparam int DEPTH   = 2048;
  localparam int LATENCY = 2;
  localparam int AW      = 64;
`ifdef DMEM_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [63:0]   req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready;
  logic          rsp_valid;
  logic [63:0]   rsp_rdata;
  logic          rsp_err;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y86_dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .AW      (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    string       name;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " req_ready"}, 64'(req_ready), 64'd1);
  endtask

  // Issue one request, then check its response (or absence of one) against the scoreboard.
  task automatic do_req(input vec_t v);
    int   cyc;
    bit   saw;
    exp_t e;
    wait_ready(v.name);
    if (!v.we || WR_ACK) begin
      e.rdata = v.we ? 64'd0 : v.exp_rdata;
      e.err   = v.exp_err;
      sb_q.push_back(e);
    end
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    // Post-accept changes must not matter.
    req_valid = 1'b0; req_we = ~v.we; req_addr = 64'h5A5A_0000_0000_0003; req_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    if (!v.we || WR_ACK) begin
      cyc = 0;
      while (!rsp_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check({v.name, " latency"}, 64'(cyc), 64'(LATENCY));
      e = sb_q.pop_front();
      check({v.name, " rdata"}, rsp_rdata, e.rdata);
      check({v.name, " err"}, 64'(rsp_err), 64'(e.err));
      check({v.name, " busy_in_resp"}, 64'(busy), 64'd1);
      $display("TXN %-8s we=%0d addr=0x%016h rdata=0x%016h err=%0d lat=%0d",
               v.name, v.we, v.addr, rsp_rdata, rsp_err, cyc);
      @(negedge clk);
      check({v.name, " retired"}, 64'(rsp_valid), 64'd0);
      check({v.name, " idle_after"}, 64'(req_ready), 64'd1);
    end else begin
      saw = 1'b0;
      repeat (LATENCY + 2) begin
        if (rsp_valid) saw = 1'b1;
        @(negedge clk);
      end
      check({v.name, " no_write_rsp"}, 64'(saw), 64'd0);
      check({v.name, " idle_after"}, 64'(req_ready), 64'd1);
      $display("TXN %-8s we=1 addr=0x%016h wdata=0x%016h (no response beat)", v.name, v.addr, v.wdata);
    end
  endtask

  initial begin
    exp_t e;
    vec_t v;
    int   cyc;
    bit   saw;

    add_vec("w100",  1'b1, 64'h100, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
    add_vec("w108",  1'b1, 64'h108, 64'hA0A1_A2A3_A4A5_A6A7, 64'd0, 1'b0);
    add_vec("r100",  1'b0, 64'h100, 64'd0, 64'h1122_3344_5566_7788, 1'b0);
    add_vec("r101",  1'b0, 64'h101, 64'd0, 64'hA711_2233_4455_6677, 1'b0);
    add_vec("r104",  1'b0, 64'h104, 64'd0, 64'hA4A5_A6A7_1122_3344, 1'b0);
    add_vec("r108",  1'b0, 64'h108, 64'd0, 64'hA0A1_A2A3_A4A5_A6A7, 1'b0);
    add_vec("wtop",  1'b1, 64'(DEPTH - 8), 64'hCAFE_BABE_DEAD_BEEF, 64'd0, 1'b0);
    add_vec("rtop",  1'b0, 64'(DEPTH - 8), 64'd0, 64'hCAFE_BABE_DEAD_BEEF, 1'b0);
    add_vec("rtop+1",1'b0, 64'(DEPTH - 7), 64'd0, 64'd0, 1'b1);
    add_vec("rwrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 1'b1);
    add_vec("rdepth",1'b0, 64'(DEPTH), 64'd0, 64'd0, 1'b1);
    add_vec("wtop+1",1'b1, 64'(DEPTH - 7), 64'h0123_4567_89AB_CDEF, 64'd0, 1'b1);
    add_vec("rtop2", 1'b0, 64'(DEPTH - 8), 64'd0, 64'hCAFE_BABE_DEAD_BEEF, 1'b0);
    add_vec("w10",   1'b1, 64'h10, 64'h8877_6655_4433_2211, 64'd0, 1'b0);
    add_vec("r10",   1'b0, 64'h10, 64'd0, 64'h8877_6655_4433_2211, 1'b0);
    add_vec("w200",  1'b1, 64'h200, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 1'b0);

    // Reset state, both during and after reset.
    repeat (3) @(negedge clk);
    check("rst req_ready", 64'(req_ready), 64'd1);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst rsp_rdata", rsp_rdata, 64'd0);
    check("rst rsp_err", 64'(rsp_err), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", 64'(req_ready), 64'd1);
    check("post_rst busy", 64'(busy), 64'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i]);
    end

    // Backpressure: response held for 5 cycles while a new request is presented.
    rsp_ready = 1'b0;
    wait_ready("bp");
    e.rdata = 64'h1122_3344_5566_7788; e.err = 1'b0;
    sb_q.push_back(e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h100;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp latency", 64'(cyc), 64'(LATENCY));
    e = sb_q.pop_front();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h100; req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d rsp_valid", k), 64'(rsp_valid), 64'd1);
      check($sformatf("bp%0d rdata", k), rsp_rdata, e.rdata);
      check($sformatf("bp%0d err", k), 64'(rsp_err), 64'(e.err));
      check($sformatf("bp%0d req_ready", k), 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp retire rsp_valid", 64'(rsp_valid), 64'd0);
    check("bp retire no_accept", 64'(busy), 64'd0);
    $display("TXN bp       read 0x100 held 5 cycles, rdata=0x%016h", e.rdata);
    req_valid = 1'b0;
    @(negedge clk);
    check("bp idle", 64'(busy), 64'd0);
    v.name = "r100_bp"; v.we = 1'b0; v.addr = 64'h100; v.wdata = 64'd0;
    v.exp_rdata = 64'h1122_3344_5566_7788; v.exp_err = 1'b0;
    do_req(v);

    // Reset during BUSY drops the pending write and any response.
    wait_ready("rstmid");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h200; req_wdata = 64'hAAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid async busy", 64'(busy), 64'd0);
    check("rstmid async req_ready", 64'(req_ready), 64'd1);
    check("rstmid async rdata", rsp_rdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (LATENCY + 3) begin
      if (rsp_valid) saw = 1'b1;
      @(negedge clk);
    end
    check("rstmid no_rsp", 64'(saw), 64'd0);
    $display("TXN rstmid   write 0x200 aborted by reset");
    v.name = "r200"; v.we = 1'b0; v.addr = 64'h200; v.wdata = 64'd0;
    v.exp_rdata = 64'h0F0E_0D0C_0B0A_0908; v.exp_err = 1'b0;
    do_req(v);

    check("sb empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%016h expected 0x%016h", 64'd0, 64'd1);
    $fatal(1, "timeout");
  end

endmodule
